// File: rtl/row_delay_buf.sv
// =============================================================================
// row_delay_buf : programmable-depth sample delay (circular buffer + fill/run)
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module row_delay_buf #(
  parameter int DATA_WIDH = 20,
  parameter int ADDR_WIDH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic [ADDR_WIDH:0]   len_i,
  input  logic                 en_i,
  input  logic [DATA_WIDH-1:0] data_i,
  output logic                 en_o,
  output logic [DATA_WIDH-1:0] data_o,
  output logic                 hvld_o,
  output logic                 fill_o
);

  localparam int                 DEPTH    = 1 << ADDR_WIDH;
  localparam logic [ADDR_WIDH:0] LEN_ONE  = {{ADDR_WIDH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDH:0] LEN_MAX  = {1'b1, {ADDR_WIDH{1'b0}}};
  localparam logic [ADDR_WIDH-1:0] PTR_ONE = {{(ADDR_WIDH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_WIDH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDH:0]   wcnt_q, wcnt_d;
  logic [ADDR_WIDH:0]   len_q, len_d;
  logic                 en_q;
  logic [DATA_WIDH-1:0] data_q;
  logic                 hvld_q;

  logic [DATA_WIDH-1:0] mem [DEPTH];

  logic [ADDR_WIDH:0]   len_sat;
  logic [ADDR_WIDH:0]   len_cur;
  logic                 wptr_last;
  logic                 accept;

  always_comb begin
    len_sat = len_i;
    if (len_i == '0) begin
      len_sat = LEN_ONE;
    end else if (len_i > LEN_MAX) begin
      len_sat = LEN_MAX;
    end
  end

  // The enable that leaves IDLE already wraps against the length it latches.
  assign len_cur   = (state_q == IDLE) ? len_sat : len_q;
  assign wptr_last = ({1'b0, wptr_q} == (len_cur - LEN_ONE));
  assign accept    = en_i & ~clr_i;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    wcnt_d  = wcnt_q;
    len_d   = len_q;
    if (clr_i) begin
      state_d = IDLE;
      wptr_d  = '0;
      wcnt_d  = '0;
    end else if (en_i) begin
      wptr_d = wptr_last ? '0 : (wptr_q + PTR_ONE);
      case (state_q)
        IDLE: begin
          len_d   = len_sat;
          wcnt_d  = LEN_ONE;
          state_d = (len_sat == LEN_ONE) ? RUN : FILL;
        end
        FILL: begin
          wcnt_d = wcnt_q + LEN_ONE;
          if ((wcnt_q + LEN_ONE) == len_q) begin
            state_d = RUN;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      wcnt_q  <= '0;
      len_q   <= LEN_ONE;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
    end
  end

  // Read-before-write: mem[wptr_q] still holds the sample from len_q enables ago.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      data_q <= '0;
      hvld_q <= 1'b0;
    end else begin
      en_q <= accept;
      if (clr_i) begin
        data_q <= '0;
        hvld_q <= 1'b0;
      end else if (en_i) begin
        data_q <= (state_q == RUN) ? mem[wptr_q] : '0;
        hvld_q <= (state_q == RUN);
      end
    end
  end

  assign en_o   = en_q;
  assign data_o = data_q;
  assign hvld_o = hvld_q;
  assign fill_o = (state_q != RUN);

endmodule

`default_nettype wire

// File: tb/tb_row_delay_buf.sv
// =============================================================================
// tb_row_delay_buf : random + directed bench against a sample-history model
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_row_delay_buf;

  localparam int DW = 20;
  localparam int AW = 10;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          clr_i  = 1'b0;
  logic          en_i   = 1'b0;
  logic [AW:0]   len_i  = '0;
  logic [DW-1:0] data_i = '0;
  logic          en_o;
  logic [DW-1:0] data_o;
  logic          hvld_o;
  logic          fill_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  row_delay_buf #(.DATA_WIDH(DW), .ADDR_WIDH(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr_i),
    .len_i  (len_i),
    .en_i   (en_i),
    .data_i (data_i),
    .en_o   (en_o),
    .data_o (data_o),
    .hvld_o (hvld_o),
    .fill_o (fill_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input logic [AW:0] l);
    if (l == '0) return 1;
    if (int'(l) > (1 << AW)) return 1 << AW;
    return int'(l);
  endfunction

  // Model: every enable of a stream is numbered; enable n returns sample n-L.
  bit            m_idle = 1'b1;
  int            m_len  = 1;
  int            m_n    = 0;
  logic [DW-1:0] m_hist [$];
  logic          m_en   = 1'b0;
  logic          m_h    = 1'b0;
  logic          m_fill = 1'b1;
  logic [DW-1:0] m_d    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_len = 1; m_n = 0; m_hist.delete();
      m_en = 1'b0; m_h = 1'b0; m_d = '0;
    end else begin
      m_en = en_i && !clr_i;
      if (clr_i) begin
        m_idle = 1'b1; m_n = 0; m_hist.delete(); m_h = 1'b0; m_d = '0;
      end else if (en_i) begin
        if (m_idle) begin
          m_len  = sat(len_i);
          m_idle = 1'b0;
        end
        if (m_n >= m_len) begin
          m_d = m_hist[m_n - m_len];
          m_h = 1'b1;
        end else begin
          m_d = '0;
          m_h = 1'b0;
        end
        m_hist.push_back(data_i);
        m_n++;
      end
    end
    m_fill = m_idle || (m_n < m_len);
  end

  bit            cmp_on = 1'b0;
  logic [DW-1:0] log_d [$];
  bit            log_h [$];

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("en_o",   32'(en_o),   32'(m_en));
      chk("hvld_o", 32'(hvld_o), 32'(m_h));
      chk("data_o", 32'(data_o), 32'(m_d));
      chk("fill_o", 32'(fill_o), 32'(m_fill));
      if (en_o === 1'b1) begin
        log_d.push_back(data_o);
        log_h.push_back(hvld_o);
      end
    end
  end

  task automatic step(input bit en, input int d, input int len, input bit clr);
    en_i   = en;
    data_i = DW'(d);
    len_i  = (AW+1)'(len);
    clr_i  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b0);
    log_d.delete();
    log_h.delete();
  endtask

  task automatic chk_log(input string name, input int idx, input bit h, input int d);
    if (idx >= log_d.size()) begin
      chk({name, "_missing"}, 32'(log_d.size()), 32'(idx + 1));
    end else begin
      chk({name, "_hvld"}, 32'(log_h[idx]), 32'(h));
      chk({name, "_data"}, 32'(log_d[idx]), 32'(d));
    end
  endtask

  initial begin
    #12;
    chk("rst_en_o",   32'(en_o),   32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_hvld_o", 32'(hvld_o), 32'd0);
    chk("rst_fill_o", 32'(fill_o), 32'd1);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    step(1'b0, 0, 0, 1'b0);

    // Test 1: len 3, back-to-back
    restart();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, i, 3, 1'b0);
      if (i == 2) chk("t1_fill_before", 32'(fill_o), 32'd1);
      if (i == 3) chk("t1_fill_after",  32'(fill_o), 32'd0);
    end
    step(1'b0, 0, 3, 1'b0);
    chk("t1_count", 32'(log_d.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_log("t1", i, i >= 3, (i >= 3) ? i - 2 : 0);

    // Test 2: len 1 with gaps
    restart();
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 10 * i, 1, 1'b0);
      repeat ($urandom_range(0, 3)) step(1'b0, 0, 1, 1'b0);
    end
    step(1'b0, 0, 1, 1'b0);
    chk_log("t2_0", 0, 1'b0, 0);
    chk_log("t2_1", 1, 1'b1, 10);
    chk_log("t2_2", 2, 1'b1, 20);

    // Test 3: maximum length, pointer wrap
    restart();
    for (int k = 0; k < 2048; k++) step(1'b1, k, 1 << AW, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk("t3_count", 32'(log_d.size()), 32'd2048);
    chk_log("t3_1023", 1023, 1'b0, 0);
    chk_log("t3_1024", 1024, 1'b1, 0);
    chk_log("t3_1500", 1500, 1'b1, 476);
    chk_log("t3_2047", 2047, 1'b1, 1023);

    // Test 4: clear coincident with an enable
    restart();
    for (int i = 0; i < 8; i++) step(1'b1, 50 + i, 4, 1'b0);
    step(1'b1, 99, 4, 1'b1);
    chk("t4_en_o",   32'(en_o),   32'd0);
    chk("t4_fill_o", 32'(fill_o), 32'd1);
    step(1'b0, 0, 4, 1'b0);
    log_d.delete();
    log_h.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 200 + i, 2, 1'b0);
    step(1'b0, 0, 2, 1'b0);
    chk_log("t4_0", 0, 1'b0, 0);
    chk_log("t4_1", 1, 1'b0, 0);
    chk_log("t4_2", 2, 1'b1, 200);

    // Test 5: len 0 behaves as len 1
    restart();
    for (int i = 5; i <= 7; i++) step(1'b1, i, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk_log("t5_0", 0, 1'b0, 0);
    chk_log("t5_1", 1, 1'b1, 5);
    chk_log("t5_2", 2, 1'b1, 6);

    // Test 6: asynchronous reset mid-stream
    restart();
    for (int i = 1; i <= 5; i++) step(1'b1, i, 3, 1'b0);
    en_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_data_o", 32'(data_o), 32'd0);
    chk("t6_hvld_o", 32'(hvld_o), 32'd0);
    chk("t6_en_o",   32'(en_o),   32'd0);
    chk("t6_fill_o", 32'(fill_o), 32'd1);
    @(posedge clk); #1;
    step(1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    log_d.delete();
    log_h.delete();
    for (int i = 11; i <= 14; i++) step(1'b1, i, 3, 1'b0);
    step(1'b0, 0, 3, 1'b0);
    for (int i = 0; i < 3; i++) chk_log("t6_fill", i, 1'b0, 0);
    chk_log("t6_run", 3, 1'b1, 11);

    // Randomized streams: lengths, density, stray len_i, mid-stream clears
    for (int s = 0; s < 30; s++) begin
      int r;
      int len;
      int nsmp;
      restart();
      r = int'($urandom_range(0, 9));
      if (r == 0)      len = 0;
      else if (r == 1) len = int'($urandom_range(1025, 2047));
      else             len = int'($urandom_range(1, 12));
      nsmp = (r == 1) ? 1100 : int'($urandom_range(20, 200));
      for (int i = 0; i < nsmp; i++) begin
        bit en;
        bit clr;
        int l;
        en  = ($urandom_range(0, 99) < 70);
        clr = ($urandom_range(0, 99) < 2);
        l   = ($urandom_range(0, 1) == 0) ? len : int'($urandom_range(0, 15));
        step(en, int'($urandom), l, clr);
      end
    end
    step(1'b0, 0, 0, 1'b0);
    cmp_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
